// File: rtl/variable_interval_timer.sv
// Interval timer: one TimeoutPulse every N base ticks (PRESCALE clocks per tick),
// where N = max(BASE_TICKS - Speed, MIN_TICKS). Supports periodic/one-shot, pause and restart.
module variable_interval_timer #(
    parameter int PRESCALE   = 5000000,
    parameter int CNT_W      = 8,
    parameter int SPEED_W    = 4,
    parameter int BASE_TICKS = 6,
    parameter int MIN_TICKS  = 1,
    parameter int PCNT_W     = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Enable,
    input  logic               Mode,
    input  logic               Pause,
    input  logic               Restart,
    input  logic [SPEED_W-1:0] Speed,
    output logic               TimeoutPulse,
    output logic               Busy,
    output logic [PCNT_W-1:0]  PulseCount
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = ((CNT_W > SPEED_W) ? CNT_W : SPEED_W) + 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    typedef struct packed {
        logic [PW-1:0]    pre;
        logic [CNT_W-1:0] tick;
        logic [CNT_W-1:0] n;
    } cnt_t;

    state_t              state;
    cnt_t                cnt;
    logic signed [DW-1:0] diff;
    logic [CNT_W-1:0]    n_calc;
    logic                tick_ev;
    logic                timeout;

    // One extra sign bit so a large Speed clamps to MIN_TICKS instead of wrapping.
    always_comb begin
        diff    = $signed(DW'(BASE_TICKS)) - $signed(DW'(Speed));
        n_calc  = (diff < $signed(DW'(MIN_TICKS))) ? CNT_W'(MIN_TICKS) : diff[CNT_W-1:0];
        tick_ev = (cnt.pre == PRE_LAST);
        timeout = tick_ev && (cnt.tick == cnt.n - CNT_W'(1));
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state        <= IDLE;
            cnt          <= '0;
            TimeoutPulse <= 1'b0;
            Busy         <= 1'b0;
            PulseCount   <= '0;
        end else begin
            TimeoutPulse <= 1'b0;
            if (!Enable) begin
                state      <= IDLE;
                cnt        <= '0;
                Busy       <= 1'b0;
                PulseCount <= '0;
            end else if (state == IDLE || Restart) begin
                state <= RUN;
                cnt   <= '{pre: '0, tick: '0, n: n_calc};
                Busy  <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        // The Pause edge itself still counts; frozen edges are those spent in PAUSED.
                        if (timeout) begin
                            TimeoutPulse <= 1'b1;
                            PulseCount   <= PulseCount + 1'b1;
                            cnt.pre      <= '0;
                            cnt.tick     <= '0;
                            if (Mode) begin
                                state <= DONE;
                                Busy  <= 1'b0;
                            end else begin
                                cnt.n <= n_calc;
                                state <= Pause ? PAUSED : RUN;
                            end
                        end else begin
                            cnt.pre <= tick_ev ? '0 : cnt.pre + 1'b1;
                            if (tick_ev)
                                cnt.tick <= cnt.tick + 1'b1;
                            state <= Pause ? PAUSED : RUN;
                        end
                    end
                    PAUSED: begin
                        if (!Pause)
                            state <= RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_variable_interval_timer.sv
// Randomized + directed bench; a remaining-cycles model predicts pulses into a queue
// that a negedge monitor drains against the DUT.
module tb_variable_interval_timer;

    localparam int P    = 4;
    localparam int PCW  = 2;
    localparam int BASE = 6;
    localparam int MINT = 1;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Enable = 1'b0;
    logic       Mode = 1'b0;
    logic       Pause = 1'b0;
    logic       Restart = 1'b0;
    logic [3:0] Speed = 4'd0;
    logic       TimeoutPulse;
    logic       Busy;
    logic [PCW-1:0] PulseCount;

    variable_interval_timer #(
        .PRESCALE(P), .CNT_W(8), .SPEED_W(4), .BASE_TICKS(BASE), .MIN_TICKS(MINT), .PCNT_W(PCW)
    ) dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .Mode(Mode), .Pause(Pause),
        .Restart(Restart), .Speed(Speed), .TimeoutPulse(TimeoutPulse),
        .Busy(Busy), .PulseCount(PulseCount)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct { int tag; int cnt; } exp_t;
    exp_t q[$];
    exp_t mon_e;

    // model: 0 idle, 1 run, 2 paused, 3 done; m_rem = active edges left in this interval
    int m_st = 0, m_rem = 0, m_cnt = 0, m_busy = 0;
    int last_pulse = -1;

    task automatic check(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge Clk) begin
        if (TimeoutPulse) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got pulse want none (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                check("pulse_cycle", cyc, mon_e.tag);
                check("pulse_count", int'(PulseCount), mon_e.cnt);
            end
            last_pulse = cyc;
        end else if (q.size() > 0 && q[0].tag <= cyc) begin
            total++;
            bad++;
            $display("FAIL missed_pulse: got none want pulse at cycle %0d", q[0].tag);
            void'(q.pop_front());
        end
        check("busy", int'(Busy), m_busy);
        check("count", int'(PulseCount), m_cnt);
    end

    task automatic model_reset();
        m_st = 0; m_rem = 0; m_cnt = 0; m_busy = 0;
    endtask

    // Outcome of the coming rising edge given the inputs now applied.
    task automatic model_edge();
        int nval;
        nval = BASE - int'(Speed);
        if (nval < MINT) nval = MINT;
        if (!Rst) model_reset();
        else if (!Enable) model_reset();
        else if (m_st == 0 || Restart) begin
            m_st = 1; m_rem = nval * P; m_busy = 1;
        end else if (m_st == 1) begin
            m_rem--;
            if (m_rem == 0) begin
                m_cnt = (m_cnt + 1) % (1 << PCW);
                q.push_back('{cyc + 1, m_cnt});
                if (Mode) begin
                    m_st = 3; m_busy = 0;
                end else begin
                    m_rem = nval * P;
                    m_st = Pause ? 2 : 1;
                end
            end else m_st = Pause ? 2 : 1;
        end else if (m_st == 2 && !Pause) m_st = 1;
    endtask

    task automatic step();
        model_edge();
        @(negedge Clk);
        #1;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int entry, rs;

    initial begin
        #2 Rst = 1'b0;
        @(negedge Clk);
        #1;
        check("rst_pulse", int'(TimeoutPulse), 0);
        check("rst_busy", int'(Busy), 0);
        check("rst_count", int'(PulseCount), 0);
        steps(3);
        Rst = 1'b1;
        steps(2);

        // 1: N=5 periodic, pulses at 20/40/60
        Speed = 4'd1; Mode = 1'b0; Enable = 1'b1;
        entry = cyc + 1; step();
        steps(60);
        check("t1_third_pulse", last_pulse - entry, 60);
        check("t1_count", int'(PulseCount), 3);
        Enable = 1'b0; steps(2);

        // 2: clamp to N=1, then Speed change takes effect after next reload
        Speed = 4'd15; Enable = 1'b1;
        entry = cyc + 1; step();
        steps(9);
        check("t2_clamped", last_pulse - entry, 8);
        Speed = 4'd2;
        steps(20);
        check("t2_relatch", last_pulse - entry, 28);
        Enable = 1'b0; steps(2);

        // 3: one-shot, then Restart at 100
        Speed = 4'd1; Mode = 1'b1; Enable = 1'b1;
        entry = cyc + 1; step();
        steps(20);
        check("t3_oneshot", last_pulse - entry, 20);
        check("t3_busy_low", int'(Busy), 0);
        steps(79);
        check("t3_no_more", last_pulse - entry, 20);
        Restart = 1'b1; rs = cyc + 1; step(); Restart = 1'b0;
        steps(20);
        check("t3_restart", last_pulse - rs, 20);
        Enable = 1'b0; Mode = 1'b0; steps(2);

        // 4: pause 7 cycles from cycle 10
        Enable = 1'b1;
        entry = cyc + 1; step();
        steps(9);
        Pause = 1'b1; steps(7); Pause = 1'b0;
        steps(12);
        check("t4_paused", last_pulse - entry, 27);

        // 5: Restart, then Enable low, on a timeout edge
        Enable = 1'b0; steps(2); Enable = 1'b1;
        entry = cyc + 1; step();
        steps(19);
        Restart = 1'b1; rs = cyc + 1; step(); Restart = 1'b0;
        check("t5_restart_nopulse", int'(last_pulse >= rs), 0);
        steps(20);
        check("t5_after_restart", last_pulse - rs, 20);
        steps(19);
        Enable = 1'b0; step();
        check("t5_en_low_cnt", int'(PulseCount), 0);
        check("t5_en_low_busy", int'(Busy), 0);
        check("t5_en_low_nopulse", last_pulse - rs, 20);
        step();

        // 6: async reset mid-interval, then wrap of PulseCount
        Enable = 1'b1;
        step(); steps(10);
        #1 Rst = 1'b0;
        model_reset();
        #1;
        check("t6_async_pulse", int'(TimeoutPulse), 0);
        check("t6_async_busy", int'(Busy), 0);
        check("t6_async_count", int'(PulseCount), 0);
        steps(2);
        Rst = 1'b1;
        entry = cyc + 1; step();
        steps(20);
        check("t6_first", last_pulse - entry, 20);
        steps(80);
        check("t6_wrap", int'(PulseCount), 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            Enable  = ($urandom_range(99) != 0);
            Restart = ($urandom_range(49) == 0);
            if ($urandom_range(19) == 0) Pause = ~Pause;
            Mode = ($urandom_range(3) == 0);
            if ($urandom_range(9) == 0) Speed = 4'($urandom);
            step();
        end

        Enable = 1'b0; Restart = 1'b0; Pause = 1'b0;
        steps(3);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/variable_interval_timer.md
Name: variable_interval_timer

Overview:
Parametrised interval timer that generates a 1-cycle TimeoutPulse every N base ticks. The base tick period is set by an internal prescaler (PRESCALE clocks per tick). N is derived from a Speed input and clamped against underflow. Adds periodic/one-shot modes, pause, restart, per-interval Speed latching and a pulse counter; intended for game-speed and event pacing logic.

Parameters:
PRESCALE, 5000000, clocks per base tick (100 ms at 50 MHz); must be >= 1
CNT_W, 8, width of tick counter; must satisfy BASE_TICKS < 2^CNT_W
SPEED_W, 4, width of Speed input
BASE_TICKS, 6, interval before speed offset: N = BASE_TICKS - Speed
MIN_TICKS, 1, floor on N; must be >= 1
PCNT_W, 8, width of PulseCount

Ports:
Clk  in  1  system clock, all logic on rising edge
Rst  in  1  asynchronous active-low reset
Enable  in  1  high = timer active; low = force IDLE and clear
Mode  in  1  0 = periodic, 1 = one-shot
Pause  in  1  high = freeze counting (RUN only)
Restart  in  1  1-cycle strobe: clear counters, relatch Speed, enter RUN
Speed  in  SPEED_W  speed value, unsigned
TimeoutPulse  out  1  1-cycle registered timeout strobe
Busy  out  1  high in RUN or PAUSED
PulseCount  out  PCNT_W  timeouts since enable, wraps modulo 2^PCNT_W

Behaviour:
- Reset (Rst=0, async): state IDLE; prescaler, tick counter, latched N = 0; TimeoutPulse=0, Busy=0, PulseCount=0.
- States: IDLE, RUN, PAUSED, DONE. Registered outputs: TimeoutPulse, Busy, PulseCount.
- Priority per edge: Enable low > Restart > timeout > Pause.
- Enable low in any state: next state IDLE; counters and PulseCount cleared; TimeoutPulse=0. This holds even if a timeout would occur on that edge.
- IDLE -> RUN on the first edge with Enable=1. On that edge: prescaler=0, tick=0, N latched.
- N computation: signed difference BASE_TICKS - Speed at width max(CNT_W, SPEED_W)+1. If result < MIN_TICKS, N = MIN_TICKS. No wrap-around is allowed. Example: BASE=6, Speed=15 gives N=1.
- N latch points: IDLE->RUN, Restart, and each periodic reload. Speed changes mid-interval have no effect until the next latch.
- RUN counting: the prescaler increments each cycle. When it equals PRESCALE-1, it wraps to 0 and a tick occurs. On a tick, tick increments.
- Timeout: a tick occurs with tick == N-1. TimeoutPulse is high for exactly the next cycle. The first pulse is asserted exactly N*PRESCALE edges after the RUN-entry edge. PulseCount increments on the same edge the pulse is asserted.
- Periodic mode (Mode=0): on timeout, tick=0 and N is relatched; stay in RUN. The period is exactly N*PRESCALE cycles with no dead cycle.
- One-shot mode (Mode=1): on timeout, go to DONE; Busy=0. DONE holds until Restart or Enable low; no further pulses.
- Mode is sampled only at timeout.
- Pause: RUN -> PAUSED when Pause=1 (no timeout on that edge). Prescaler and tick are frozen. PAUSED -> RUN when Pause=0; counting resumes from the frozen values. The total active cycles per interval are unchanged.
- Timeout on the same edge as Pause=1: the pulse is issued and the reload occurs, then the state is PAUSED. In one-shot mode the state is DONE.
- Restart (with Enable=1) from RUN, PAUSED or DONE: prescaler=0, tick=0, N relatched, state RUN. No pulse is issued even if a timeout coincides. PulseCount is kept.
- Restart in IDLE: treated as Enable entry only.
- TimeoutPulse is never high for more than 1 consecutive cycle, except PRESCALE=1 with N=1 in periodic mode, where it is continuously high.
- Busy = 1 in RUN/PAUSED, 0 in IDLE/DONE. Updated on the edge that enters the state.

Test Plan:
1. Defaults except PRESCALE=4; Speed=1, Mode=0, Enable rises -> N=5; pulses at 20, 40, 60 cycles after entry; PulseCount=1,2,3.
2. PRESCALE=4, Speed=15 -> N clamped to 1; pulse every 4 cycles. Then Speed=2 mid-interval -> the current interval stays at 4 cycles, the next interval is 16 cycles.
3. PRESCALE=4, Speed=1, Mode=1 -> single pulse at cycle 20, Busy falls at 20, no pulse through cycle 100. Restart at 100 -> pulse at 120.
4. PRESCALE=4, N=5; Pause high for 7 cycles starting at cycle 10 -> pulse at cycle 27; Busy stays 1.
5. Timeout-edge collisions: Restart on the timeout edge -> no pulse, next pulse 20 cycles later. Enable low on the timeout edge -> no pulse, PulseCount=0, Busy=0.
6. Async reset asserted mid-interval, between clock edges -> all outputs 0 immediately. After release with Enable=1 -> first pulse at 20 cycles. PCNT_W=2, run 5 pulses -> PulseCount wraps 1,2,3,0,1.
